// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable RV32I data memory behind a req/rsp handshake.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses as errors.
package pkg_config;
    localparam int DATA_WIDTH = 32;
endpackage

module dmem_lsu
    import pkg_config::*;
#(
    parameter int MEM_SIZE     = 1024,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = $clog2(MEM_SIZE) + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  accept;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  illegal;
    logic                  misalign;
    logic                  err;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wword;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] ldata;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;

    logic [DATA_WIDTH-1:0] pend_rdata_q;
    logic                  pend_err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign req_ready_o = (state_q != S_WAIT);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign accept = req_valid_i && req_ready_o;
    assign idx    = req_addr_i[ADDR_WIDTH-1:2];
    assign wr_en  = accept && req_we_i && !err && rst_ni;

    // Decode funct3: legality, alignment and the effective lane.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        lane     = 2'd0;
        if (req_we_i) begin
            illegal = (req_funct3_i > 3'd2);
        end else begin
            illegal = (req_funct3_i == 3'd3) ||
                      (req_funct3_i == 3'd6) ||
                      (req_funct3_i == 3'd7);
        end
        case (req_funct3_i[1:0])
            2'd0:    lane = req_addr_i[1:0];
            2'd1:    lane = {req_addr_i[1], 1'b0};
            default: lane = 2'd0;
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((req_funct3_i[1:0] == 2'd1) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'd2) &&
                    (req_addr_i[1:0] != 2'd0));
`else
        misalign = 1'b0;
`endif
        err = illegal || misalign;
    end

    // Store lane enables and replicated write data.
    always_comb begin
        be    = 4'b0000;
        wword = req_wdata_i;
        case (req_funct3_i[1:0])
            2'd0: begin
                be    = 4'b0001 << lane;
                wword = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{req_wdata_i[15:0]}};
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Read the addressed word and extend the selected lane.
    always_comb begin
        rword = mem[idx];
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        ldata = '0;
        unique case (1'b1)
            (req_funct3_i == 3'd0): ldata = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
            (req_funct3_i == 3'd1): ldata = {{(DATA_WIDTH-16){rhalf[15]}}, rhalf};
            (req_funct3_i == 3'd2): ldata = rword;
            (req_funct3_i == 3'd4): ldata = {{(DATA_WIDTH-8){1'b0}}, rbyte};
            (req_funct3_i == 3'd5): ldata = {{(DATA_WIDTH-16){1'b0}}, rhalf};
            default:                ldata = '0;
        endcase
        if (err || req_we_i) begin
            ldata = '0;
        end
    end

    // Byte-lane write into the array at the acceptance edge.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    // Next-state logic for the latency counter FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            if (READ_LATENCY == 1) begin
                state_d = S_RESP;
                cnt_d   = 3'd0;
            end else begin
                state_d = S_WAIT;
                cnt_d   = 3'(READ_LATENCY - 1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the result at accept; publish it only on entry to RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                pend_rdata_q <= ldata;
                pend_err_q   <= err;
            end
            if (state_d == S_RESP) begin
                rdata_q <= accept ? ldata : pend_rdata_q;
                err_q   <= accept ? err : pend_err_q;
            end
        end
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Byte-addressable RV32I data memory with a load/store request/response handshake. Supports all RV32I load and store widths (LB/LH/LW/LBU/LHU, SB/SH/SW), with lane merging on stores and sign/zero extension on loads. Read latency is configurable. Sits between the core's memory stage and the data array and replaces the word-only, combinational-read `data_memory`.

## Interface
Parameters:
- `MEM_SIZE`, 1024: depth in 32-bit words; power of two.
- `READ_LATENCY`, 1: cycles from acceptance to response; legal range 1..4.
- `ADDR_WIDTH`, `$clog2(MEM_SIZE)+2`: byte-address width (derived; do not override).

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request this cycle.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_funct3_i`  in  3  RV32I load/store funct3.
- `req_addr_i`  in  `ADDR_WIDTH`  byte address.
- `req_wdata_i`  in  `DATA_WIDTH` (32, from `pkg_config`)  store data, right-aligned.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  `DATA_WIDTH`  extended load data; 0 for stores and errors.
- `rsp_err_o`  out  1  illegal funct3, or misaligned access (see Configuration).

## Operation
- **Accept:** a request is accepted on an edge where `req_valid_i && req_ready_o`. All request inputs are sampled at that edge only.
- **Word index:** `req_addr_i[ADDR_WIDTH-1:2]`.
- **Lanes:** the byte lane is `addr[1:0]`; the halfword lane is `addr[1]`.
- **Store, legal request:**
  - The memory write happens at the acceptance edge.
  - SB (funct3 0) writes one lane from `wdata[7:0]`.
  - SH (funct3 1) writes two lanes from `wdata[15:0]`.
  - SW (funct3 2) writes all four lanes.
  - Unselected lanes are preserved.
- **Load, legal request:**
  - The word is read at the acceptance edge and registered.
  - LB (0) and LH (1) sign-extend; LW (2) returns the word; LBU (4) and LHU (5) zero-extend.
- **Illegal funct3:**
  - Load funct3 3, 6 or 7, or store funct3 3 to 7.
  - Response has `rsp_err_o` = 1 and `rsp_rdata_o` = 0; no write occurs.
- **Erroring store:** memory is never modified.
- **Memory contents:** not reset and not initialised.
- **State machine** (`cnt` = remaining cycles until the response):
  - IDLE: `req_ready_o` = 1.
    - On accept, go to RESP if `READ_LATENCY` = 1; otherwise go to WAIT with `cnt` = `READ_LATENCY`-1.
  - WAIT: `req_ready_o` = 0.
    - Decrement `cnt` each cycle; go to RESP when `cnt` reaches 1.
  - RESP: `rsp_valid_o` = 1 and `req_ready_o` = 1.
    - On a new accept, go to WAIT or RESP as from IDLE; otherwise go to IDLE.
- **Outputs between responses:** `rsp_rdata_o` and `rsp_err_o` are meaningful only while `rsp_valid_o` = 1, and hold their last value otherwise.

## Timing
- **Reset** (asynchronous, while `rst_ni` = 0):
  - State IDLE, `cnt` = 0.
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - `req_ready_o` = 1.
- **Latency:** a request accepted at edge N gives `rsp_valid_o` high for exactly the cycle following edge N+`READ_LATENCY`-1. With latency 1, that is the cycle right after acceptance.
- **Throughput:** one request every `READ_LATENCY` cycles; back-to-back at latency 1.
- **No response backpressure:** the consumer must take the response during the pulse.
- **Ordering:**
  - A load accepted any edge after a store to the same word returns the stored data.
  - This includes a load accepted in the RESP cycle of that store.
- **Reset mid-operation:** pending responses are dropped, and no `rsp_valid_o` follows. Writes already committed remain in memory.

## Configuration
- **Macro:** `DMEM_MISALIGN_CHECK_EN`.
- **Defined** — misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0:
  - Response has `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
  - No write occurs.
- **Undefined:**
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`; the access is forced aligned.
  - `rsp_err_o` flags illegal funct3 only.

## Test plan
- **SW/LW round trip** (`READ_LATENCY`=1): SW 0xDEADBEEF @0x10, then LW @0x10 -> response 1 cycle after accept, rdata 0xDEADBEEF, err 0.
- **Byte store and extension:** SB 0x000000A5 @0x13, then loads:
  - LB @0x13 -> 0xFFFFFFA5.
  - LBU @0x13 -> 0x000000A5.
  - LW @0x10 -> 0xA5ADBEEF.
- **Halfword store and extension:** SH 0x00008001 @0x12, then loads:
  - LH @0x12 -> 0xFFFF8001.
  - LHU @0x12 -> 0x00008001.
  - LW @0x10 -> 0x8001BEEF.
- **Misalignment** (preload 0x11223344 @0x20):
  - With the macro: LW @0x21 -> err 1, rdata 0; SW 0xFFFFFFFF @0x22 leaves the word at 0x20 unchanged.
  - Without the macro: LW @0x21 -> 0x11223344, err 0.
- **Latency 3, illegal funct3:** `READ_LATENCY`=3 with back-to-back requests:
  - `req_ready_o` low for 2 cycles after each accept.
  - `rsp_valid_o` is a single pulse in the cycle after accept edge N+2.
  - Load funct3=3 -> err 1, rdata 0.
- **Reset mid-WAIT:** SW @0x30 accepted, then `rst_ni` asserted during WAIT:
  - `rsp_valid_o` = 0 and `req_ready_o` = 1 while in reset.
  - After release, LW @0x30 returns the stored word.
